// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank.
//   rgb_t           : packed {r,g,b} colour at the reference 4-bit channel width
//   DEFAULT_PALETTE : 16 x 12-bit power-on contents of bank 0, index 0 in the low word
//   clr_state_t     : bank-clear engine states
//   FLASH_WHITE     : colour forced onto opaque pixels during the hit-flash phase
package sprite_palette_pkg;

   localparam int unsigned PAL_COLOR_W = 4;

   typedef struct packed {
      logic [PAL_COLOR_W-1:0] r;
      logic [PAL_COLOR_W-1:0] g;
      logic [PAL_COLOR_W-1:0] b;
   } rgb_t;

   // Index 1 is the magenta chroma key.
   localparam logic [15:0][11:0] DEFAULT_PALETTE = {
      12'h222, 12'h555, 12'hAAA, 12'hFFF,  // 15..12
      12'h048, 12'h06F, 12'h0A0, 12'hC00,  // 11..8
      12'hF80, 12'hFC0, 12'h630, 12'hA52,  // 7..4
      12'hC84, 12'hEED, 12'hF0F, 12'h000   // 3..0
   };

   localparam rgb_t FLASH_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/palette_clear_fsm.sv
// Bank-clear engine and palette write-port arbiter.
//   clk_i, rst_ni            : clock, async active-low reset
//   clr_req_i, clr_bank_i    : start zeroing one bank
//   clr_busy_o               : clear in progress
//   wr_valid_i/wr_ready_o    : external write handshake; wr_bank_i, wr_index_i, wr_color_i
//   mem_we_o, mem_bank_o,
//   mem_index_o, mem_data_o  : the single muxed write into the palette storage
module palette_clear_fsm
   import sprite_palette_pkg::*;
#(
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned COLOR_W   = 4,
   parameter int unsigned BANK_W    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_req_i,
   input  logic [BANK_W-1:0]    clr_bank_i,
   output logic                 clr_busy_o,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [BANK_W-1:0]    wr_bank_i,
   input  logic [IDX_W-1:0]     wr_index_i,
   input  logic [3*COLOR_W-1:0] wr_color_i,
   output logic                 mem_we_o,
   output logic [BANK_W-1:0]    mem_bank_o,
   output logic [IDX_W-1:0]     mem_index_o,
   output logic [3*COLOR_W-1:0] mem_data_o
);

   localparam int unsigned BW1 = BANK_W + 1;
   localparam logic [BANK_W:0] NumBanksL = BW1'(NUM_BANKS);
   localparam logic [IDX_W-1:0] LastIdx = '1;

   clr_state_t        state_q;
   logic [BANK_W-1:0] bank_q;
   logic [IDX_W-1:0]  ptr_q;
   logic              busy_q;
   logic              clr_ok;
   logic              wr_ok;

   // Out-of-range banks only exist when NUM_BANKS is not a power of two.
   assign clr_ok = {1'b0, clr_bank_i} < NumBanksL;
   assign wr_ok  = {1'b0, wr_bank_i} < NumBanksL;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         bank_q  <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (clr_req_i && clr_ok) begin
                  state_q <= CLEAR;
                  bank_q  <= clr_bank_i;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LastIdx) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy_o = busy_q;
   assign wr_ready_o = ~busy_q;

   // The clear engine owns the write port while busy; external writes stall.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_bank_o  = wr_bank_i;
      mem_index_o = wr_index_i;
      mem_data_o  = wr_color_i;
      if (busy_q) begin
         mem_we_o    = 1'b1;
         mem_bank_o  = bank_q;
         mem_index_o = ptr_q;
         mem_data_o  = '0;
      end else begin
         mem_we_o = wr_valid_i && wr_ok;
      end
   end

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable sprite palette: pixel index -> RGB through a 2-stage pipeline.
//   Clk, Reset_n                 : clock, async active-low reset
//   frame_start, bank_sel        : display bank is switched only on frame_start
//   pix_valid, pix_index         : lookup request
//   out_valid, red/green/blue,
//   transparent                  : lookup result, 2 cycles after the request
//   wr_valid/wr_ready, wr_bank,
//   wr_index, wr_color           : runtime palette load port
//   clr_req, clr_bank, clr_busy  : bank clear engine
//   flash_en                     : hit-flash effect, phase toggles every FLASH_PERIOD frames
module sprite_palette_bank
   import sprite_palette_pkg::*;
#(
   parameter int unsigned IDX_W           = 4,
   parameter int unsigned NUM_BANKS       = 4,
   parameter int unsigned COLOR_W         = 4,
   parameter int unsigned TRANSPARENT_IDX = 1,
   parameter int unsigned FLASH_PERIOD    = 4,
   parameter int unsigned BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 frame_start,
   input  logic [BANK_W-1:0]    bank_sel,
   input  logic                 pix_valid,
   input  logic [IDX_W-1:0]     pix_index,
   output logic                 out_valid,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 transparent,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [BANK_W-1:0]    wr_bank,
   input  logic [IDX_W-1:0]     wr_index,
   input  logic [3*COLOR_W-1:0] wr_color,
   input  logic                 clr_req,
   input  logic [BANK_W-1:0]    clr_bank,
   output logic                 clr_busy,
   input  logic                 flash_en
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned CW      = 3 * COLOR_W;
   localparam int unsigned FL_W    = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
   localparam int unsigned BW1     = BANK_W + 1;
   localparam logic [BANK_W:0]  NumBanksL = BW1'(NUM_BANKS);
   localparam logic [FL_W-1:0]  LastCnt   = FL_W'(FLASH_PERIOD - 1);
   localparam logic [IDX_W-1:0] TranspIdx = IDX_W'(TRANSPARENT_IDX);

   // Stretch/truncate a reference 4-bit-per-channel colour to COLOR_W, MSB aligned.
   function automatic logic [CW-1:0] expand(input logic [11:0] c12);
      rgb_t            p;
      logic [CW-1:0]   e;
      int unsigned     src;
      p = rgb_t'(c12);
      e = '0;
      for (int unsigned b = 0; b < COLOR_W; b++) begin
         src = 3 - (((COLOR_W - 1 - b) * 4) / COLOR_W);
         e[2*COLOR_W+b] = p.r[src[1:0]];
         e[COLOR_W+b]   = p.g[src[1:0]];
         e[b]           = p.b[src[1:0]];
      end
      return e;
   endfunction

   localparam logic [CW-1:0] WhiteC = expand(FLASH_WHITE);

   logic [CW-1:0]     mem_q [NUM_BANKS][ENTRIES];
   logic [BANK_W-1:0] active_bank_q;
   logic              mem_we;
   logic [BANK_W-1:0] mem_bank;
   logic [IDX_W-1:0]  mem_index;
   logic [CW-1:0]     mem_data;

   logic              s1_valid_q;
   logic [IDX_W-1:0]  s1_index_q;
   logic [CW-1:0]     s1_color_q;
   logic              s2_valid_q;
   logic              s2_transp_q;
   logic [CW-1:0]     s2_color_q;
   logic              s1_is_transp;

   logic [FL_W-1:0]   flash_cnt_q;
   logic              flash_phase_q;

   palette_clear_fsm #(
      .IDX_W     (IDX_W),
      .NUM_BANKS (NUM_BANKS),
      .COLOR_W   (COLOR_W),
      .BANK_W    (BANK_W)
   ) u_clear_fsm (
      .clk_i       (Clk),
      .rst_ni      (Reset_n),
      .clr_req_i   (clr_req),
      .clr_bank_i  (clr_bank),
      .clr_busy_o  (clr_busy),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready),
      .wr_bank_i   (wr_bank),
      .wr_index_i  (wr_index),
      .wr_color_i  (wr_color),
      .mem_we_o    (mem_we),
      .mem_bank_o  (mem_bank),
      .mem_index_o (mem_index),
      .mem_data_o  (mem_data)
   );

   // Palette storage; flops so reset can restore the default bank.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
               mem_q[b][i] <= (b == 0) ? expand(DEFAULT_PALETTE[i[3:0]]) : '0;
            end
         end
      end else if (mem_we) begin
         mem_q[mem_bank][mem_index] <= mem_data;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         active_bank_q <= '0;
      end else if (frame_start && ({1'b0, bank_sel} < NumBanksL)) begin
         active_bank_q <= bank_sel;
      end
   end

   // S1 reads storage before this edge's write lands, giving read-first collisions.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid_q <= 1'b0;
         s1_index_q <= '0;
         s1_color_q <= '0;
      end else begin
         s1_valid_q <= pix_valid;
         if (pix_valid) begin
            s1_index_q <= pix_index;
            s1_color_q <= mem_q[active_bank_q][pix_index];
         end
      end
   end

   assign s1_is_transp = (s1_index_q == TranspIdx);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_valid_q  <= 1'b0;
         s2_transp_q <= 1'b0;
         s2_color_q  <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_transp_q <= s1_is_transp;
            s2_color_q  <= (flash_phase_q && !s1_is_transp) ? WhiteC : s1_color_q;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         flash_cnt_q   <= '0;
         flash_phase_q <= 1'b0;
      end else if (!flash_en) begin
         flash_cnt_q   <= '0;
         flash_phase_q <= 1'b0;
      end else if (frame_start) begin
         if (flash_cnt_q == LastCnt) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= ~flash_phase_q;
         end else begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign transparent = s2_transp_q;
   assign red         = s2_color_q[3*COLOR_W-1:2*COLOR_W];
   assign green       = s2_color_q[2*COLOR_W-1:COLOR_W];
   assign blue        = s2_color_q[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
module tb_sprite_palette_bank;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [1:0]  bank_sel = 2'd0;
   logic        pix_valid = 1'b0;
   logic [3:0]  pix_index = 4'd0;
   logic        out_valid;
   logic [3:0]  red, green, blue;
   logic        transparent;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [1:0]  wr_bank = 2'd0;
   logic [3:0]  wr_index = 4'd0;
   logic [11:0] wr_color = 12'h000;
   logic        clr_req = 1'b0;
   logic [1:0]  clr_bank = 2'd0;
   logic        clr_busy;
   logic        flash_en = 1'b0;

   int checks = 0;
   int errors = 0;

   sprite_palette_bank dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .bank_sel    (bank_sel),
      .pix_valid   (pix_valid),
      .pix_index   (pix_index),
      .out_valid   (out_valid),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .transparent (transparent),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_bank     (wr_bank),
      .wr_index    (wr_index),
      .wr_color    (wr_color),
      .clr_req     (clr_req),
      .clr_bank    (clr_bank),
      .clr_busy    (clr_busy),
      .flash_en    (flash_en)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic lookup(input logic [3:0] idx);
      pix_valid = 1'b1;
      pix_index = idx;
      tick();
      pix_valid = 1'b0;
      tick();
   endtask

   task automatic chk_pix(input string tag, input logic [11:0] rgb, input logic t);
      chk({tag, "_valid"}, 12'(out_valid), 12'h001);
      chk({tag, "_rgb"}, {red, green, blue}, rgb);
      chk({tag, "_transp"}, 12'(transparent), 12'(t));
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 12'(out_valid), 12'h000);
      chk("rst_rgb", {red, green, blue}, 12'h000);
      chk("rst_transp", 12'(transparent), 12'h000);
      chk("rst_wr_ready", 12'(wr_ready), 12'h001);
      chk("rst_clr_busy", 12'(clr_busy), 12'h000);
      Reset_n = 1'b1;
      tick();

      // Two-cycle latency on default bank 0
      pix_valid = 1'b1;
      pix_index = 4'd2;
      tick();
      chk("lat_1cyc_valid", 12'(out_valid), 12'h000);
      pix_valid = 1'b0;
      tick();
      chk_pix("idx2_default", 12'hEED, 1'b0);
      lookup(4'd1);
      chk_pix("idx1_key", 12'hF0F, 1'b1);
      tick();
      chk("hold_valid", 12'(out_valid), 12'h000);
      chk("hold_rgb", {red, green, blue}, 12'hF0F);

      // Write bank1, mid-frame bank_sel change has no effect
      wr_valid = 1'b1;
      wr_bank  = 2'd1;
      wr_index = 4'd5;
      wr_color = 12'h123;
      tick();
      wr_valid = 1'b0;
      bank_sel = 2'd1;
      lookup(4'd5);
      chk_pix("midframe_idx5", 12'h630, 1'b0);
      // Lookup in the frame_start cycle still uses the old bank
      frame_start = 1'b1;
      pix_valid   = 1'b1;
      pix_index   = 4'd5;
      tick();
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      tick();
      chk_pix("fs_cycle_idx5", 12'h630, 1'b0);
      lookup(4'd5);
      chk_pix("bank1_idx5", 12'h123, 1'b0);

      // Back to bank 0, read/write collision is read-first
      bank_sel = 2'd0;
      frame();
      wr_valid  = 1'b1;
      wr_bank   = 2'd0;
      wr_index  = 4'd3;
      wr_color  = 12'hABC;
      pix_valid = 1'b1;
      pix_index = 4'd3;
      tick();
      wr_valid  = 1'b0;
      pix_valid = 1'b0;
      tick();
      chk_pix("collide_old", 12'hC84, 1'b0);
      lookup(4'd3);
      chk_pix("collide_new", 12'hABC, 1'b0);

      // Hit flash, period 4
      flash_en = 1'b1;
      repeat (3) frame();
      lookup(4'd2);
      chk_pix("flash_f3", 12'hEED, 1'b0);
      frame();
      lookup(4'd2);
      chk_pix("flash_f4_opaque", 12'hFFF, 1'b0);
      lookup(4'd1);
      chk_pix("flash_f4_key", 12'hF0F, 1'b1);
      repeat (4) frame();
      lookup(4'd2);
      chk_pix("flash_f8", 12'hEED, 1'b0);
      repeat (4) frame();
      lookup(4'd2);
      chk_pix("flash_f12", 12'hFFF, 1'b0);
      flash_en = 1'b0;
      lookup(4'd2);
      chk_pix("flash_off", 12'hEED, 1'b0);

      // Clear bank 0 with a write held pending
      clr_req  = 1'b1;
      clr_bank = 2'd0;
      tick();
      clr_req  = 1'b0;
      wr_valid = 1'b1;
      wr_bank  = 2'd2;
      wr_index = 4'd7;
      wr_color = 12'h456;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("clr_busy_c%0d", i + 1), {10'd0, clr_busy, wr_ready}, 12'h002);
         tick();
      end
      chk("clr_done_c17", {10'd0, clr_busy, wr_ready}, 12'h001);
      tick();
      wr_valid = 1'b0;
      lookup(4'd2);
      chk_pix("cleared_idx2", 12'h000, 1'b0);
      lookup(4'd3);
      chk_pix("cleared_idx3", 12'h000, 1'b0);
      bank_sel = 2'd1;
      frame();
      lookup(4'd5);
      chk_pix("bank1_kept", 12'h123, 1'b0);
      bank_sel = 2'd2;
      frame();
      lookup(4'd7);
      chk_pix("held_write", 12'h456, 1'b0);

      // Reset mid-clear at ptr 7
      clr_req  = 1'b1;
      clr_bank = 2'd0;
      tick();
      clr_req = 1'b0;
      repeat (7) tick();
      chk("midclr_busy", 12'(clr_busy), 12'h001);
      Reset_n = 1'b0;
      #1;
      chk("arst_clr_busy", 12'(clr_busy), 12'h000);
      chk("arst_wr_ready", 12'(wr_ready), 12'h001);
      chk("arst_out_valid", 12'(out_valid), 12'h000);
      tick();
      Reset_n = 1'b1;
      tick();
      lookup(4'd7);
      chk_pix("arst_active0_idx7", 12'hF80, 1'b0);
      lookup(4'd2);
      chk_pix("arst_idx2", 12'hEED, 1'b0);
      lookup(4'd12);
      chk_pix("arst_idx12", 12'hFFF, 1'b0);
      lookup(4'd3);
      chk_pix("arst_idx3", 12'hC84, 1'b0);
      frame();
      lookup(4'd7);
      chk_pix("arst_bank2_zero", 12'h000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Multi-bank, writable sprite palette that succeeds the fixed per-sprite palette ROMs. It maps a pixel index from the sprite ROM path to 12-bit RGB through a 2-stage lookup pipeline. Frame-synchronous bank switching lets one block serve every character, pose and colour variant. It also provides a runtime load port with handshake, a bank-clear engine, chroma-key transparency and a hit-flash effect. It sits between the sprite address/index fetch and the VGA colour mux.

Parameters:
IDX_W, 4, pixel index width; entries per bank = 2**IDX_W
NUM_BANKS, 4, number of palette banks; BANK_W = $clog2(NUM_BANKS), minimum 1
COLOR_W, 4, bits per colour channel
TRANSPARENT_IDX, 1, index reported as transparent (magenta key)
FLASH_PERIOD, 4, frame_start pulses per flash phase toggle, >= 1

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame
bank_sel  in  BANK_W  requested display bank, sampled at frame_start
pix_valid  in  1  pixel lookup request
pix_index  in  IDX_W  pixel palette index
out_valid  out  1  pix_valid delayed 2 cycles
red, green, blue  out  COLOR_W each  looked-up colour
transparent  out  1  pixel index equals TRANSPARENT_IDX
wr_valid  in  1  palette write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_bank  in  BANK_W  target bank
wr_index  in  IDX_W  target entry
wr_color  in  3*COLOR_W  {r,g,b}
clr_req  in  1  start clearing clr_bank to 0
clr_bank  in  BANK_W  bank to clear
clr_busy  out  1  clear in progress
flash_en  in  1  enable hit-flash

Behaviour:
- Reset (async, Reset_n=0): bank 0 loads DEFAULT_PALETTE; all other banks load 0.
- Reset outputs: active_bank=0, out_valid=0, RGB=0, transparent=0, wr_ready=1, clr_busy=0, flash counter=0, flash phase=0.
- Active bank: active_bank <= bank_sel only on a cycle with frame_start=1. A bank_sel change mid-frame has no effect until the next frame_start. A lookup in the same cycle as frame_start uses the old bank.
- Lookup pipeline, fixed 2-cycle latency, no stall:
  - S1 registers valid, index and active_bank, and reads the entry.
  - S2 registers colour, transparent and valid.
  - Output holds its last value when out_valid=0.
- Read/write collision: a write to the entry being read in S1 in the same cycle returns the old value (read-first). The next lookup sees the new value.
- Write: committed at the clock edge where wr_valid && wr_ready. Writes to any bank are allowed, including the active bank.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req; latches clr_bank; ptr=0.
  - In CLEAR: writes 0 to entry ptr each cycle, ptr++. After entry 2**IDX_W-1 it returns to IDLE.
  - Takes exactly 2**IDX_W cycles.
  - clr_busy=1 and wr_ready=0 while in CLEAR. clr_req is ignored while in CLEAR.
  - clr_req together with an accepted write in IDLE: the write commits, and CLEAR starts the next cycle, so it overwrites that entry if the banks match.
  - Lookups continue during CLEAR. Entries already cleared read 0.
- Flash:
  - When flash_en=0, counter and phase are held at 0.
  - When flash_en=1, each frame_start increments the counter. On reaching FLASH_PERIOD-1 the counter wraps to 0 and phase toggles.
  - Phase=1 forces S2 RGB to all-ones for non-transparent pixels. Transparent pixels keep their stored colour.
  - Dropping flash_en returns phase to 0 on the next cycle.
- Width rules: index and bank are used unsigned. When NUM_BANKS is not a power of two, an out-of-range bank on bank_sel, wr_bank or clr_bank is ignored: the active bank is kept, the write is dropped, the clear does not start.

Decomposition:
- Package sprite_palette_pkg holds:
  - the rgb_t struct {r,g,b} with COLOR_W fields;
  - DEFAULT_PALETTE, 16 x 12-bit, including entries 0=0x000, 1=0xF0F, 2=0xEED, 12=0xFFF;
  - the clr_state_t enum {IDLE, CLEAR};
  - FLASH_WHITE.
- One sub-module, palette_clear_fsm: state, ptr, clr_busy, and the write-port arbitration that generates wr_ready and the muxed write enable/address/data.

Test Plan:
- Reset, then a lookup of idx 2 on bank 0 -> out_valid 2 cycles later, RGB=E,E,D, transparent=0. A lookup of idx 1 -> F,0,F with transparent=1.
- Write bank1 idx5=0x123; bank_sel=1 mid-frame; look up idx5 -> still bank0 value. After a frame_start pulse, idx5 -> 1,2,3.
- Same-cycle write of bank0 idx3=0xABC and S1 read of idx3 -> old value. The next read -> A,B,C.
- clr_req on bank0 -> clr_busy=1 and wr_ready=0 for 16 cycles. A wr_valid held throughout is accepted on cycle 17. Afterwards idx2 reads 0 and bank1 is unchanged.
- flash_en=1 with FLASH_PERIOD=4 -> the 4th frame_start sets phase=1 and idx2 reads F,F,F while idx1 stays F,0,F. The 8th frame_start clears phase. Dropping flash_en gives normal colours the next cycle.
- Reset_n asserted mid-clear at ptr=7 -> clr_busy=0 at once, bank0 equals DEFAULT_PALETTE, active_bank=0.
